// File: rtl/ncoin_pkg.sv
// Shared types and constants for the ncoin RMII receive path.
package ncoin_pkg;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_PREAMB = 2'd1,
        RX_BODY   = 2'd2,
        RX_DROP   = 2'd3
    } rx_state_t;

    // Byte offsets of the header fields from the first byte after the SFD.
    localparam int DST_OFF   = 0;
    localparam int SRC_OFF   = 6;
    localparam int TYPE_OFF  = 12;
    localparam int VER_OFF   = 14;
    localparam int NTYPE_OFF = 15;
    localparam int HASH_OFF  = 16;
    localparam int HDR_BYTES = 32;

    localparam logic [12:0] MIN_DIBITS = 13'd256;
    localparam logic [12:0] MAX_DIBITS = 13'd6072;

    // 01 dibits still required after the one that moved IDLE into PREAMB.
    localparam logic [2:0] PREAMB_LOAD = 3'd7;

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    localparam logic [15:0] DEFAULT_ETH_TYPE = 16'hc0de;

    // Turns a MAC written MSB-first into wire order with the first byte in [7:0].
    function automatic logic [47:0] byte_rev48(input logic [47:0] v);
        logic [47:0] r;
        for (int i = 0; i < 6; i++) begin
            r[8*i +: 8] = v[47-8*i -: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_rx_chk.sv
// Reflected CRC-32 advanced one RMII dibit per enabled cycle; ok flags the good-frame residue.
module crc32_rx_chk
    import ncoin_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic       en,
    input  logic [1:0] d,
    output logic       ok
);

    logic [31:0] crc;
    logic [31:0] crc_nxt;

    always_comb begin
        crc_nxt = crc;
        for (int i = 0; i < 2; i++) begin
            if (crc_nxt[0] ^ d[i]) begin
                crc_nxt = (crc_nxt >> 1) ^ CRC_POLY;
            end else begin
                crc_nxt = crc_nxt >> 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc <= CRC_INIT;
        end else if (init) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc_nxt;
        end
    end

    assign ok = (crc == CRC_RESIDUE);

endmodule

// File: rtl/mac_rx.sv
// RMII receiver for ncoin frames: address/type filtering and hash hand-off.
// FCS checking is built only when MAC_RX_CRC_CHECK_EN is defined.
//
// state     | meaning
// RX_IDLE   | waiting for a 01 dibit with crs_dv (armed once crs_dv has been low)
// RX_PREAMB | counting 01 preamble dibits until the 11 SFD
// RX_BODY   | shifting frame dibits into header/CRC until crs_dv falls
// RX_DROP   | ignoring the rest of a bad preamble until crs_dv falls
module mac_rx
    import ncoin_pkg::*;
#(
    parameter logic [47:0] MY_MAC         = 48'h02_00_00_00_00_01,
    parameter logic [15:0] NCOIN_ETH_TYPE = DEFAULT_ETH_TYPE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   rx_d,
    input  logic         crs_dv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [47:0]  out_src_mac,
    output logic         crc_err,
    output logic         overrun
);

    rx_state_t state, state_nxt;

    logic                   armed;
    logic [2:0]             pre_left;
    logic [12:0]            cnt;
    logic [HDR_BYTES*8-1:0] hdr;
    logic                   body_en;
    logic                   frame_end;
    logic                   frame_ok;
    logic                   crc_ok;
    logic                   acc_s1;
    logic                   acc_s2;
    logic                   hold_pending;

    logic [47:0]  f_dst;
    logic [47:0]  f_src;
    logic [15:0]  f_type;
    logic [7:0]   f_ver;
    logic [7:0]   f_ntype;
    logic [127:0] f_hash;

    assign f_dst   = hdr[DST_OFF*8   +: 48];
    assign f_src   = hdr[SRC_OFF*8   +: 48];
    assign f_type  = hdr[TYPE_OFF*8  +: 16];
    assign f_ver   = hdr[VER_OFF*8   +: 8];
    assign f_ntype = hdr[NTYPE_OFF*8 +: 8];
    assign f_hash  = hdr[HASH_OFF*8  +: 128];

    always_comb begin
        state_nxt = state;
        body_en   = 1'b0;
        frame_end = 1'b0;
        unique case (state)
            RX_IDLE: begin
                if (armed && crs_dv && rx_d == 2'b01) state_nxt = RX_PREAMB;
            end
            RX_PREAMB: begin
                if (!crs_dv) begin
                    state_nxt = RX_IDLE;
                end else if (rx_d == 2'b01) begin
                    state_nxt = RX_PREAMB;
                end else if (rx_d == 2'b11 && pre_left == 3'd0) begin
                    state_nxt = RX_BODY;
                end else begin
                    state_nxt = RX_DROP;
                end
            end
            RX_BODY: begin
                if (crs_dv) begin
                    body_en = 1'b1;
                end else begin
                    frame_end = 1'b1;
                    state_nxt = RX_IDLE;
                end
            end
            RX_DROP: begin
                if (!crs_dv) state_nxt = RX_IDLE;
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RX_IDLE;
            armed    <= 1'b0;
            pre_left <= PREAMB_LOAD;
            cnt      <= '0;
            hdr      <= '0;
        end else begin
            state <= state_nxt;
            if (!crs_dv) armed <= 1'b1;
            if (state == RX_IDLE) begin
                pre_left <= PREAMB_LOAD;
            end else if (state == RX_PREAMB && rx_d == 2'b01 && pre_left != 3'd0) begin
                pre_left <= pre_left - 3'd1;
            end
            if (state == RX_PREAMB && state_nxt == RX_BODY) begin
                cnt <= '0;
            end else if (body_en) begin
                if (cnt != '1) cnt <= cnt + 13'd1;
                if (cnt < 13'(HDR_BYTES*4)) hdr[{cnt[6:0], 1'b0} +: 2] <= rx_d;
            end
        end
    end

`ifdef MAC_RX_CRC_CHECK_EN
    logic crc_init;

    assign crc_init = (state == RX_PREAMB) && (state_nxt == RX_BODY);

    crc32_rx_chk u_crc (
        .clk  (clk),
        .rst  (rst),
        .init (crc_init),
        .en   (body_en),
        .d    (rx_d),
        .ok   (crc_ok)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_err <= 1'b0;
        end else begin
            crc_err <= frame_end && !crc_ok;
        end
    end
`else
    assign crc_ok  = 1'b1;
    assign crc_err = 1'b0;
`endif

    assign frame_ok = (cnt >= MIN_DIBITS) && (cnt <= MAX_DIBITS) && (cnt[1:0] == 2'b00)
                   && (f_dst == byte_rev48(MY_MAC) || f_dst == '1)
                   && (f_type == {NCOIN_ETH_TYPE[7:0], NCOIN_ETH_TYPE[15:8]})
                   && (f_ver == 8'd1) && (f_ntype == 8'd1) && crc_ok;

    assign hold_pending = out_valid && !out_ready;

    // Two-stage delay to the hand-off; hdr cannot be rewritten that soon because
    // a new frame needs a full preamble before reaching BODY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_s1      <= 1'b0;
            acc_s2      <= 1'b0;
            overrun     <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_src_mac <= '0;
        end else begin
            acc_s1  <= frame_end && frame_ok;
            acc_s2  <= acc_s1;
            overrun <= acc_s2 && hold_pending;
            if (acc_s2 && !hold_pending) begin
                out_valid   <= 1'b1;
                out_data    <= f_hash;
                out_src_mac <= f_src;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
